// File: rtl/ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ula_pkg                                                                    |
// | CDB word layout helpers and unit identifiers shared by the ULA family.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ula_pkg;

  localparam int c_onehot_max_w = 32;
  localparam int c_cdb_max_w    = 128;

  localparam logic UNIT_ID_LDSD = 1'b0;
  localparam logic UNIT_ID_ALU  = 1'b1;

  // CDB word, MSB to LSB: one-hot dest | RS slot | unit id | address
  function automatic int cdb_id_bit(input int addr_w);
    return addr_w;
  endfunction

  function automatic int cdb_rs_lsb(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int cdb_dest_lsb(input int rs_pos_w, input int addr_w);
    return addr_w + 1 + rs_pos_w;
  endfunction

  function automatic int cdb_width(input int num_regs, input int rs_pos_w, input int addr_w);
    return num_regs + rs_pos_w + 1 + addr_w;
  endfunction

  function automatic logic [c_cdb_max_w-1:0] cdb_invalid_word(input int width);
    logic [c_cdb_max_w-1:0] w;
    w = '0;
    for (int i = 0; i < c_cdb_max_w; i++) begin
      if (i < width) w[i] = 1'b1;
    end
    return w;
  endfunction

  // R0 sits in the MSB of the field; out-of-range indices decode to all zeros
  function automatic logic [c_onehot_max_w-1:0] onehot_dest(input int idx, input int num_regs);
    logic [c_onehot_max_w-1:0] oh;
    oh = '0;
    if (idx >= 0 && idx < num_regs) oh[num_regs-1-idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_ld_sd_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ula_ld_sd_pipe_if                                                          |
// | Issue handshake and CDB presentation bundle of the LD/SD address unit.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ula_ld_sd_pipe_if #(
  parameter int DATA_W    = 16,
  parameter int IMM_W     = 4,
  parameter int ADDR_W    = 10,
  parameter int NUM_REGS  = 3,
  parameter int REG_IDX_W = 3,
  parameter int RS_POS_W  = 2
);

  localparam int c_cdb_w = ula_pkg::cdb_width(NUM_REGS, RS_POS_W, ADDR_W);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    RY_data;
  logic [IMM_W-1:0]     imediate;
  logic [REG_IDX_W-1:0] reg_dest;
  logic [RS_POS_W-1:0]  RS_position;
  logic                 flush;
  logic                 cdb_valid;
  logic                 cdb_grant;
  logic [c_cdb_w-1:0]   ULA_output;
  logic                 addr_oob;
  logic                 dest_err;

  modport master (
    output in_valid, RY_data, imediate, reg_dest, RS_position, flush, cdb_grant,
    input  in_ready, cdb_valid, ULA_output, addr_oob, dest_err
  );

  modport slave (
    input  in_valid, RY_data, imediate, reg_dest, RS_position, flush, cdb_grant,
    output in_ready, cdb_valid, ULA_output, addr_oob, dest_err
  );

endinterface
`default_nettype wire

// File: rtl/ula_ld_sd_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ula_ld_sd_stage                                                            |
// | One valid+payload pipeline register; empty slots carry IDLE_VAL.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ula_ld_sd_stage #(
  parameter int           W        = 18,
  parameter logic [W-1:0] IDLE_VAL = '1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  output logic [W-1:0] out_payload
);

  logic         r_valid;
  logic [W-1:0] r_payload;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_payload <= IDLE_VAL;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_payload <= IDLE_VAL;
    end else if (en) begin
      r_valid   <= in_valid;
      r_payload <= in_valid ? in_payload : IDLE_VAL;
    end
  end

  assign out_valid   = r_valid;
  assign out_payload = r_payload;

endmodule
`default_nettype wire

// File: rtl/ula_ld_sd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ula_ld_sd_pipe                                                             |
// | Pipelined LD/SD address generator presenting a held word to the CDB.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ula_ld_sd_pipe
  import ula_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 4,
  parameter int IMM_SIGNED = 0,
  parameter int ADDR_W     = 10,
  parameter int NUM_REGS   = 3,
  parameter int REG_IDX_W  = 3,
  parameter int RS_POS_W   = 2,
  parameter int STAGES     = 1
) (
  input  logic               clock,
  input  logic               resetn,
  ula_ld_sd_pipe_if.slave    bus
);

  localparam int c_cdb_w    = cdb_width(NUM_REGS, RS_POS_W, ADDR_W);
  localparam int c_pay_w    = c_cdb_w + 2;
  localparam int c_id_bit   = cdb_id_bit(ADDR_W);
  localparam int c_rs_lsb   = cdb_rs_lsb(ADDR_W);
  localparam int c_dest_lsb = cdb_dest_lsb(RS_POS_W, ADDR_W);

  localparam logic [c_cdb_w-1:0] c_invalid  = c_cdb_w'(cdb_invalid_word(c_cdb_w));
  localparam logic [c_pay_w-1:0] c_idle_pay = {2'b00, c_invalid};

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("ula_ld_sd_pipe: STAGES must be within 1..3");
  end
  if (NUM_REGS > (2 ** REG_IDX_W)) begin : g_bad_regs
    $error("ula_ld_sd_pipe: NUM_REGS exceeds the reg_dest index range");
  end
  if (ADDR_W > DATA_W || IMM_W > DATA_W) begin : g_bad_widths
    $error("ula_ld_sd_pipe: ADDR_W and IMM_W must not exceed DATA_W");
  end
  if (c_cdb_w > c_cdb_max_w || NUM_REGS > c_onehot_max_w) begin : g_bad_cdb
    $error("ula_ld_sd_pipe: CDB word too wide for the package helpers");
  end

  logic                 w_adv;
  logic                 w_accept;
  logic [DATA_W:0]      w_imm_ext;
  logic [DATA_W:0]      w_sum;
  logic                 w_oob;
  logic                 w_dest_bad;
  logic [c_cdb_w-1:0]   w_word;
  logic [c_pay_w-1:0]   w_pay_in;

  logic [STAGES:0]                 w_stage_valid;
  logic [STAGES:0][c_pay_w-1:0]    w_stage_pay;

  // Whole pipeline moves in lock-step, gated only by the held CDB word
  assign w_adv        = ~bus.cdb_valid | bus.cdb_grant;
  assign bus.in_ready = w_adv & ~bus.flush;
  assign w_accept     = bus.in_valid & bus.in_ready;

  if (IMM_SIGNED != 0) begin : g_imm_sext
    assign w_imm_ext = {{(DATA_W + 1 - IMM_W){bus.imediate[IMM_W-1]}}, bus.imediate};
  end else begin : g_imm_zext
    assign w_imm_ext = {{(DATA_W + 1 - IMM_W){1'b0}}, bus.imediate};
  end

  // A negative signed result wraps into the top bit, so one OR covers both cases
  assign w_sum      = {1'b0, bus.RY_data} + w_imm_ext;
  assign w_oob      = |w_sum[DATA_W:ADDR_W];
  assign w_dest_bad = (32'(bus.reg_dest) >= 32'(NUM_REGS));

  always_comb begin
    w_word = '0;
    w_word[c_dest_lsb +: NUM_REGS] = NUM_REGS'(onehot_dest(32'(bus.reg_dest), NUM_REGS));
    w_word[c_rs_lsb +: RS_POS_W]   = bus.RS_position;
    w_word[c_id_bit]               = UNIT_ID_LDSD;
    w_word[0 +: ADDR_W]            = w_sum[ADDR_W-1:0];
  end

  assign w_pay_in         = {w_dest_bad, w_oob, w_word};
  assign w_stage_valid[0] = w_accept;
  assign w_stage_pay[0]   = w_pay_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ula_ld_sd_stage #(
      .W        (c_pay_w),
      .IDLE_VAL (c_idle_pay)
    ) u_stage (
      .clock       (clock),
      .resetn      (resetn),
      .en          (w_adv),
      .flush       (bus.flush),
      .in_valid    (w_stage_valid[i]),
      .in_payload  (w_stage_pay[i]),
      .out_valid   (w_stage_valid[i+1]),
      .out_payload (w_stage_pay[i+1])
    );
  end

  assign bus.cdb_valid = w_stage_valid[STAGES];
  assign {bus.dest_err, bus.addr_oob, bus.ULA_output} = w_stage_pay[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_ula_ld_sd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ula_ld_sd_pipe                                                          |
// | Three configurations driven in parallel against an op-queue model.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ula_ld_sd_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        drv_valid, drv_flush, drv_grant;
  logic [15:0] drv_ry;
  logic [3:0]  drv_imm;
  logic [2:0]  drv_dest;
  logic [1:0]  drv_rs;

  logic [2:0]       obs_valid, obs_oob, obs_derr, obs_rdy;
  logic [2:0][15:0] obs_word;

  int n_total = 0;
  int n_bad   = 0;

  // Configuration k: 0 -> 1 stage unsigned, 1 -> 3 stages signed, 2 -> 2 stages unsigned
  function automatic int stages_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic int signed_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ula_ld_sd_pipe_if bus ();
    assign bus.in_valid    = drv_valid;
    assign bus.RY_data     = drv_ry;
    assign bus.imediate    = drv_imm;
    assign bus.reg_dest    = drv_dest;
    assign bus.RS_position = drv_rs;
    assign bus.flush       = drv_flush;
    assign bus.cdb_grant   = drv_grant;
    assign obs_valid[g]    = bus.cdb_valid;
    assign obs_word[g]     = bus.ULA_output;
    assign obs_oob[g]      = bus.addr_oob;
    assign obs_derr[g]     = bus.dest_err;
    assign obs_rdy[g]      = bus.in_ready;

    ula_ld_sd_pipe #(
      .STAGES     (stages_of(g)),
      .IMM_SIGNED (signed_of(g))
    ) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
    );
  end

  // Each in-flight op remembers how many stages deep it is
  typedef struct packed {
    logic [15:0] word;
    logic        oob;
    logic        derr;
    logic [3:0]  pos;
  } ent_t;

  ent_t mq [3][$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t make_ent(input int k);
    ent_t       e;
    int         off;
    int         s;
    int         a;
    logic [2:0] oh;
    off = int'(drv_imm);
    if (signed_of(k) != 0 && off >= 8) off = off - 16;
    s      = int'(drv_ry) + off;
    a      = s & 1023;
    oh     = (drv_dest < 3'd3) ? (3'b100 >> drv_dest) : 3'b000;
    e.word = {oh, drv_rs, 1'b0, a[9:0]};
    e.oob  = (s < 0) || (s >= 1024);
    e.derr = (drv_dest >= 3'd3);
    e.pos  = 4'd1;
    return e;
  endfunction

  task automatic model_out(input int k, output logic v, output logic [15:0] w,
                           output logic oob, output logic derr);
    v = 1'b0; w = 16'hFFFF; oob = 1'b0; derr = 1'b0;
    if (mq[k].size() > 0 && int'(mq[k][0].pos) == stages_of(k)) begin
      v    = 1'b1;
      w    = mq[k][0].word;
      oob  = mq[k][0].oob;
      derr = mq[k][0].derr;
    end
  endtask

  task automatic compare_all();
    logic        v, oob, derr, rdy;
    logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      model_out(k, v, w, oob, derr);
      rdy = (~v | drv_grant) & ~drv_flush;
      check_val($sformatf("d%0d.cdb_valid", k), 16'(obs_valid[k]), 16'(v));
      check_val($sformatf("d%0d.ULA_output", k), obs_word[k], w);
      check_val($sformatf("d%0d.addr_oob", k), 16'(obs_oob[k]), 16'(oob));
      check_val($sformatf("d%0d.dest_err", k), 16'(obs_derr[k]), 16'(derr));
      check_val($sformatf("d%0d.in_ready", k), 16'(obs_rdy[k]), 16'(rdy));
    end
  endtask

  task automatic model_edge();
    logic        v, oob, derr;
    logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      if (!resetn || drv_flush) begin
        mq[k].delete();
      end else begin
        model_out(k, v, w, oob, derr);
        if (!v || drv_grant) begin
          if (v) void'(mq[k].pop_front());
          for (int i = 0; i < mq[k].size(); i++) mq[k][i].pos = mq[k][i].pos + 4'd1;
          if (drv_valid) mq[k].push_back(make_ent(k));
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input logic iv, input logic [15:0] ry, input logic [3:0] imm,
                      input logic [2:0] dest, input logic [1:0] rs,
                      input logic fl, input logic gr, input logic rn);
    drv_valid = iv; drv_ry = ry; drv_imm = imm; drv_dest = dest; drv_rs = rs;
    drv_flush = fl; drv_grant = gr; resetn = rn;
    #1;
    compare_all();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic gr);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 3'd0, 2'd0, 1'b0, gr, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; drv_valid = 1'b0; drv_flush = 1'b0; drv_grant = 1'b0;
    drv_ry = '0; drv_imm = '0; drv_dest = '0; drv_rs = '0;
    @(posedge clock);
    @(negedge clock);

    // Reset state, then the basic LD/SD word
    step(1'b0, 16'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0010, 4'h3, 3'd1, 2'd2, 1'b0, 1'b1, 1'b1);
    check_val("t1_word", obs_word[0], 16'h5013);
    check_val("t1_valid", 16'(obs_valid[0]), 16'h1);
    check_val("t1_oob", 16'(obs_oob[0]), 16'h0);
    idle(3, 1'b1);

    // Signed offsets on the 3-stage unit, with latency probes
    step(1'b1, 16'h0005, 4'hE, 3'd0, 2'd1, 1'b0, 1'b1, 1'b1);
    check_val("t2_lat_e0", 16'(obs_valid[1]), 16'h0);
    step(1'b1, 16'h0001, 4'hE, 3'd2, 2'd3, 1'b0, 1'b1, 1'b1);
    check_val("t2_lat_e1", 16'(obs_valid[1]), 16'h0);
    idle(1, 1'b1);
    check_val("t2_lat_e2", 16'(obs_valid[1]), 16'h1);
    check_val("t2_addr", 16'(obs_word[1][9:0]), 16'h0003);
    check_val("t2_word", obs_word[1], 16'h8803);
    check_val("t2_no_oob", 16'(obs_oob[1]), 16'h0);
    idle(1, 1'b1);
    check_val("t2_neg_oob", 16'(obs_oob[1]), 16'h1);
    idle(3, 1'b1);

    // Back-to-back fill, stall under a withheld grant, then drain in order
    step(1'b1, 16'h0020, 4'h1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0021, 4'h2, 3'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0022, 4'h3, 3'd2, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h0023, 4'h0, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1);
      check_val("t3_hold_word", obs_word[1], 16'h8021);
      check_val("t3_hold_rdy", 16'(obs_rdy[1]), 16'h0);
    end
    idle(1, 1'b1);
    check_val("t3_second", obs_word[1], 16'h4823);
    idle(1, 1'b1);
    check_val("t3_third", obs_word[1], 16'h3025);
    idle(1, 1'b1);
    check_val("t3_empty", obs_word[1], 16'hFFFF);
    idle(2, 1'b1);

    // Flush with two ops in flight on the 3-stage unit
    step(1'b1, 16'h0030, 4'h0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0031, 4'h0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0032, 4'h0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    check_val("t4_flush_valid", 16'(obs_valid[1]), 16'h0);
    check_val("t4_flush_word", obs_word[1], 16'hFFFF);
    idle(3, 1'b1);
    check_val("t4_gone", 16'(obs_valid[1]), 16'h0);

    // Out-of-range destination still delivered
    step(1'b1, 16'h0040, 4'h0, 3'd3, 2'd1, 1'b0, 1'b0, 1'b1);
    check_val("t5_derr", 16'(obs_derr[0]), 16'h1);
    check_val("t5_word", obs_word[0], 16'h0840);
    idle(1, 1'b1);
    check_val("t5_cleared", 16'(obs_valid[0]), 16'h0);
    check_val("t5_derr_clr", 16'(obs_derr[0]), 16'h0);
    idle(3, 1'b1);

    // Reset while a result is held
    step(1'b1, 16'h0050, 4'h1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("t6_valid", 16'(obs_valid[0]), 16'h0);
    check_val("t6_word", obs_word[0], 16'hFFFF);
    check_val("t6_rdy", 16'(obs_rdy[0]), 16'h1);
    idle(1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1040)),
           4'($urandom), 3'($urandom), 2'($urandom),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 99) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
